// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the convolution window datapath.
package cnn_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_WIDTH  = 28;
  localparam int unsigned DEF_HEIGHT = 28;
  localparam int unsigned DEF_K      = 3;

  // Flat element index of window position (r, c) in a k x k window, row-major.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-clock line buffer: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so the array maps onto RAM primitives.
module line_ram #(
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read returns the old word when reading and writing the same address in one cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K x K sliding-window generator over a raster-order pixel stream.
// The previous K-1 rows live in circular line buffers; the window itself is a
// register array shifted left by one column on every accepted pixel.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned K      = DEF_K,
  parameter int unsigned STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_clr,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*K*DATA_W-1:0]   out_win,
  output logic                    out_last
);

  localparam int unsigned NL     = K - 1;
  localparam int unsigned XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned PW     = (NL > 1) ? $clog2(NL) : 1;
  localparam int unsigned SW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  // Position of the final emitting pixel; equals (WIDTH-1, HEIGHT-1) when STRIDE divides evenly.
  localparam int unsigned LAST_X = (K - 1) + ((WIDTH - K) / STRIDE) * STRIDE;
  localparam int unsigned LAST_Y = (K - 1) + ((HEIGHT - K) / STRIDE) * STRIDE;

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     phx_q, phx_d;
  logic [SW-1:0]     phy_q, phy_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];
  logic [DATA_W-1:0] rd [NL];
  logic [DATA_W-1:0] new_col [K];

  logic accept, emit, row_end, frame_end;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready && !frame_clr;
  assign row_end   = (32'(x_q) == WIDTH - 1);
  assign frame_end = row_end && (32'(y_q) == HEIGHT - 1);
  assign emit      = (32'(x_q) >= K - 1) && (32'(y_q) >= K - 1) &&
                     (phx_q == '0) && (phy_q == '0);

  // Line buffer ptr_q is the one being overwritten by the current row; it holds the oldest row.
  for (genvar i = 0; i < NL; i++) begin : g_line
    line_ram #(
      .DEPTH (WIDTH),
      .DATA_W(DATA_W),
      .AW    (XW)
    ) u_line_ram (
      .clk  (clk),
      .we   (accept && (ptr_q == PW'(i))),
      .waddr(x_q),
      .wdata(in_data),
      .raddr(x_q),
      .rdata(rd[i])
    );
  end

  // Frame position, row pointer and stride phase for the next accepted pixel.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    ptr_d = ptr_q;
    phx_d = phx_q;
    phy_d = phy_q;
    if (frame_clr) begin
      x_d   = '0;
      y_d   = '0;
      ptr_d = '0;
      phx_d = '0;
      phy_d = '0;
    end else if (accept) begin
      if (row_end) begin
        x_d   = '0;
        phx_d = '0;
        if (frame_end) begin
          y_d   = '0;
          phy_d = '0;
          ptr_d = '0;
        end else begin
          y_d   = y_q + 1'b1;
          ptr_d = (ptr_q == PW'(NL - 1)) ? '0 : ptr_q + 1'b1;
          // Phase only starts counting once the window has a full column of rows.
          if (32'(y_q) >= K - 1) phy_d = (phy_q == SW'(STRIDE - 1)) ? '0 : phy_q + 1'b1;
          else                   phy_d = '0;
        end
      end else begin
        x_d = x_q + 1'b1;
        if (32'(x_q) >= K - 1) phx_d = (phx_q == SW'(STRIDE - 1)) ? '0 : phx_q + 1'b1;
        else                   phx_d = '0;
      end
    end
  end

  // Output handshake: load on an accepted pixel, drop after consumption, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (frame_clr) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (accept) begin
      out_valid_d = emit;
      out_last_d  = emit && (32'(x_q) == LAST_X) && (32'(y_q) == LAST_Y);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // New right-hand column (oldest row first) and the shifted window.
  always_comb begin
    for (int r = 0; r < K; r++) new_col[r] = in_data;
    for (int r = 0; r < NL; r++) begin
      if (int'(ptr_q) + r >= NL) new_col[r] = rd[PW'(int'(ptr_q) + r - NL)];
      else                       new_col[r] = rd[PW'(int'(ptr_q) + r)];
    end
    win_d = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c + 1];
      win_d[r][K-1] = new_col[r];
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      ptr_q       <= '0;
      phx_q       <= '0;
      phy_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      ptr_q       <= ptr_d;
      phx_q       <= phx_d;
      phy_q       <= phy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Window register array; only moves on an accepted pixel so it is stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '{default: '0};
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  // Flatten the window, row-major with (0,0) in the least significant slot.
  always_comb begin
    out_win = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        out_win[win_idx(r, c, K)*DATA_W +: DATA_W] = win_q[r][c];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: three instances (28x28 stride 1, 8x8 stride 2,
// 28x28 one-bit pixels) share stimulus, with one selected per test.
module tb_conv_window_gen;

  typedef struct packed {
    logic        last;
    logic [71:0] win;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        frame_clr;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_valid_a, in_valid_b, in_valid_c;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic        out_last_a, out_last_b, out_last_c;
  logic [71:0] out_win_a, out_win_b;
  logic [8:0]  out_win_c;

  logic        m_ready, m_valid, m_last;
  logic [71:0] m_win;

  int          sel;
  int          W, H, S, DW, TOTAL;
  int          mx, my, fidx, wif, n_acc;
  int          n_checks, n_errors;
  int          win_cnt, last_cnt;
  bit          have_first, prev_stall;
  logic [71:0] first_win, last_win, held_win;
  logic        held_last;
  exp_t        q[$];

  localparam logic [71:0] EXP_FIRST_A =
    {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] EXP_FIRST_B =
    {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] EXP_LAST_B =
    {8'd54, 8'd53, 8'd52, 8'd46, 8'd45, 8'd44, 8'd38, 8'd37, 8'd36};

  assign in_valid_a = in_valid && (sel == 0);
  assign in_valid_b = in_valid && (sel == 1);
  assign in_valid_c = in_valid && (sel == 2);

  conv_window_gen u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_clr(frame_clr),
    .in_valid (in_valid_a),
    .in_data  (in_data),
    .in_ready (in_ready_a),
    .out_valid(out_valid_a),
    .out_ready(out_ready),
    .out_win  (out_win_a),
    .out_last (out_last_a)
  );

  conv_window_gen #(
    .WIDTH (8),
    .HEIGHT(8),
    .STRIDE(2)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_clr(frame_clr),
    .in_valid (in_valid_b),
    .in_data  (in_data),
    .in_ready (in_ready_b),
    .out_valid(out_valid_b),
    .out_ready(out_ready),
    .out_win  (out_win_b),
    .out_last (out_last_b)
  );

  conv_window_gen #(
    .DATA_W(1)
  ) u_dut_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_clr(frame_clr),
    .in_valid (in_valid_c),
    .in_data  (in_data[0:0]),
    .in_ready (in_ready_c),
    .out_valid(out_valid_c),
    .out_ready(out_ready),
    .out_win  (out_win_c),
    .out_last (out_last_c)
  );

  always_comb begin
    case (sel)
      0:       begin m_ready = in_ready_a; m_valid = out_valid_a; m_last = out_last_a;
                     m_win = out_win_a; end
      1:       begin m_ready = in_ready_b; m_valid = out_valid_b; m_last = out_last_b;
                     m_win = out_win_b; end
      default: begin m_ready = in_ready_c; m_valid = out_valid_c; m_last = out_last_c;
                     m_win = {63'b0, out_win_c}; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_acc=%0d required completion", n_acc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int x, input int y, input int f);
    case (sel)
      0:       return 8'((y * 28 + x) % 256);
      1:       return 8'(y * 8 + x);
      default: return (f == 0) ? 8'd1 : 8'd0;
    endcase
  endfunction

  function automatic logic [71:0] build_win(input int x, input int y);
    logic [71:0] w;
    logic [7:0]  v;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        v = pix(x - 2 + c, y - 2 + r, fidx);
        if (DW == 8) w[(r*3+c)*8 +: 8] = v;
        else         w[r*3+c] = v[0];
      end
    end
    return w;
  endfunction

  // Reference model of one accepted pixel: queue the expected window if this pixel emits.
  task automatic model_accept();
    exp_t e;
    bit   em;
    em = (mx >= 2) && (my >= 2) && ((mx - 2) % S == 0) && ((my - 2) % S == 0);
    if (em) begin
      e.win  = build_win(mx, my);
      e.last = (wif == TOTAL - 1);
      q.push_back(e);
      wif++;
    end
    n_acc++;
    if (mx == W - 1) begin
      mx = 0;
      if (my == H - 1) begin
        my = 0;
        fidx++;
        wif = 0;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    check("in_ready", m_ready, !m_valid || out_ready);
    if (prev_stall) begin
      check("stall_valid", m_valid, 1'b1);
      check("stall_win", m_win, held_win);
      check("stall_last", m_last, held_last);
    end
    if (m_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_window", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check("win", m_win, e.win);
        check("last", m_last, e.last);
      end
      win_cnt++;
      if (m_last) begin
        last_cnt++;
        last_win = m_win;
      end
      if (!have_first) begin
        first_win  = m_win;
        have_first = 1'b1;
      end
    end
    prev_stall = m_valid && !out_ready;
    held_win   = m_win;
    held_last  = m_last;
  endtask

  task automatic do_cycle(input bit valid_en, input bit rdy, input bit clr);
    bit acc;
    @(negedge clk);
    in_valid  = valid_en;
    in_data   = valid_en ? pix(mx, my, fidx) : 8'($urandom);
    out_ready = rdy;
    frame_clr = clr;
    #1;
    monitor();
    acc = in_valid && m_ready && !clr;
    @(posedge clk);
    if (acc) model_accept();
    if (clr) begin
      q.delete();
      prev_stall = 1'b0;
      mx  = 0;
      my  = 0;
      wif = 0;
    end
  endtask

  task automatic clear_counts();
    win_cnt    = 0;
    last_cnt   = 0;
    have_first = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    frame_clr = 1'b0;
    out_ready = 1'b1;
    q.delete();
    prev_stall = 1'b0;
    mx = 0; my = 0; wif = 0; fidx = 0;
    #1;
    check("rst_valid", m_valid, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_win", m_win, 72'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
  endtask

  task automatic start_test(input int s, input int w, input int h, input int st, input int dw);
    sel   = s;
    W     = w;
    H     = h;
    S     = st;
    DW    = dw;
    TOTAL = ((W - 3) / S + 1) * ((H - 3) / S + 1);
    do_reset();
  endtask

  task automatic run_pixels(input int n, input bit rnd);
    int target;
    int budget;
    target = n_acc + n;
    budget = n * 8 + 100;
    while (n_acc < target && budget > 0) begin
      do_cycle(rnd ? ($urandom_range(0, 99) < 70) : 1'b1,
               rnd ? ($urandom_range(0, 99) >= 30) : 1'b1, 1'b0);
      budget--;
    end
    if (n_acc < target) check("pixel_budget", 72'(n_acc), 72'(target));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || m_valid); i++) do_cycle(1'b0, 1'b1, 1'b0);
    check("drain_empty", 72'(q.size()), 72'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sel = 0; W = 28; H = 28; S = 1; DW = 8; TOTAL = 676;
    mx = 0; my = 0; fidx = 0; wif = 0; n_acc = 0;
    clear_counts();

    // Full frame, no back-pressure.
    start_test(0, 28, 28, 1, 8);
    run_pixels(784, 1'b0);
    drain();
    check("t1_count", 72'(win_cnt), 72'd676);
    check("t1_lasts", 72'(last_cnt), 72'd1);
    check("t1_first", first_win, EXP_FIRST_A);

    // Stride 2 on an 8x8 frame.
    start_test(1, 8, 8, 2, 8);
    run_pixels(64, 1'b0);
    drain();
    check("t2_count", 72'(win_cnt), 72'd9);
    check("t2_lasts", 72'(last_cnt), 72'd1);
    check("t2_first", first_win, EXP_FIRST_B);
    check("t2_last_win", last_win, EXP_LAST_B);

    // Random valid and back-pressure.
    start_test(0, 28, 28, 1, 8);
    run_pixels(784, 1'b1);
    drain();
    check("t3_count", 72'(win_cnt), 72'd676);
    check("t3_lasts", 72'(last_cnt), 72'd1);
    check("t3_first", first_win, EXP_FIRST_A);

    // Reset in the middle of a frame, then a full frame.
    start_test(0, 28, 28, 1, 8);
    run_pixels(300, 1'b1);
    do_reset();
    run_pixels(784, 1'b1);
    drain();
    check("t4_count", 72'(win_cnt), 72'd676);
    check("t4_lasts", 72'(last_cnt), 72'd1);
    check("t4_first", first_win, EXP_FIRST_A);

    // Frame restart in the middle of a frame with a pixel offered in the same cycle.
    start_test(0, 28, 28, 1, 8);
    run_pixels(100, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b1);
    #1;
    check("t5_clr_valid", m_valid, 1'b0);
    check("t5_clr_last", m_last, 1'b0);
    clear_counts();
    run_pixels(784, 1'b1);
    drain();
    check("t5_count", 72'(win_cnt), 72'd676);
    check("t5_lasts", 72'(last_cnt), 72'd1);
    check("t5_first", first_win, EXP_FIRST_A);

    // One-bit pixels: all-ones frame then all-zeros frame, back to back.
    start_test(2, 28, 28, 1, 1);
    run_pixels(1568, 1'b0);
    drain();
    check("t6_count", 72'(win_cnt), 72'd1352);
    check("t6_lasts", 72'(last_cnt), 72'd2);
    check("t6_first", first_win, 72'h1ff);
    check("t6_last_win", last_win, 72'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
